// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_pkg
//  Description : Shared RV32I decode constants and enums: major opcodes,
//                ALU operation, result select and branch-type encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_opimm  = 7'b0010011;
  localparam logic [6:0] c_opc_op     = 7'b0110011;

  localparam logic [31:0] c_inst_ebreak = 32'h0010_0073;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [3:0] {
    RES_ALU  = 4'd0,
    RES_PC4  = 4'd1,
    RES_IMM  = 4'd2,
    RES_NONE = 4'd3
  } res_sel_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4,
    BR_LTU  = 3'd5,
    BR_GEU  = 3'd6,
    BR_JUMP = 3'd7
  } br_type_e;

endpackage
`default_nettype wire

// File: rtl/rv32_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_regfile
//  Description : 32-entry integer register file, x0 hardwired to zero.
//                Two combinational operand read ports plus a debug read port,
//                one synchronous write port. No write-to-read bypass.
//  Ports       : clk, rst (async active-low clear), i_wen/i_waddr/i_wdata
//                (write), i_raddr1/o_rdata1, i_raddr2/o_rdata2 (operands),
//                i_dbg_raddr/o_dbg_rdata (debug)
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32_regfile #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wen,
  input  logic [4:0]          i_waddr,
  input  logic [DATA_LEN-1:0] i_wdata,
  input  logic [4:0]          i_raddr1,
  output logic [DATA_LEN-1:0] o_rdata1,
  input  logic [4:0]          i_raddr2,
  output logic [DATA_LEN-1:0] o_rdata2,
  input  logic [4:0]          i_dbg_raddr,
  output logic [DATA_LEN-1:0] o_dbg_rdata
);

  logic [DATA_LEN-1:0] r_regs [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wen && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // x0 is forced to zero on read so its storage never matters.
  assign o_rdata1    = (i_raddr1    == 5'd0) ? '0 : r_regs[i_raddr1];
  assign o_rdata2    = (i_raddr2    == 5'd0) ? '0 : r_regs[i_raddr2];
  assign o_dbg_rdata = (i_dbg_raddr == 5'd0) ? '0 : r_regs[i_dbg_raddr];

endmodule
`default_nettype wire

// File: rtl/rv32_decode_execute_unit.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_decode_execute_unit
//  Description : Single-cycle RV32I decode/execute/write-back slice. Decodes
//                inst_i, reads operands, computes ALU result and branch
//                resolution combinationally, writes rd on the next rising edge.
//  Ports       : clk, rst (async active-low), inst_i/pc_i (fetched inst + PC),
//                branch_flag_o/branch_request_o/branch_target_o (to PC logic),
//                invalid_o/ebreak_o (status), dbg_raddr_i/dbg_rdata_o (debug)
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32_decode_execute_unit
  import rv32_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         inst_i,
  input  logic [ADDR_LEN-1:0] pc_i,
  output logic                branch_flag_o,
  output logic                branch_request_o,
  output logic [ADDR_LEN-1:0] branch_target_o,
  output logic                invalid_o,
  output logic                ebreak_o,
  input  logic [4:0]          dbg_raddr_i,
  output logic [DATA_LEN-1:0] dbg_rdata_o
);

  // ---------------------------------------------------------------- fields
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_opcode = inst_i[6:0];
  assign w_funct3 = inst_i[14:12];

  assign w_imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign w_imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign w_imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign w_imm_u = {inst_i[31:12], 12'b0};
  assign w_imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  // ---------------------------------------------------------------- decode
  logic        w_valid;
  logic        w_is_ctrl;
  logic        w_is_jalr;
  logic        w_is_ebreak;
  logic        w_a_is_pc;
  logic        w_b_is_imm;
  logic [31:0] w_imm32;
  alu_op_e     w_alu_op;
  res_sel_e    w_res_sel;
  br_type_e    w_br_type;

  assign w_is_ebreak = (inst_i == c_inst_ebreak);

  always_comb begin
    w_valid    = 1'b0;
    w_is_ctrl  = 1'b0;
    w_is_jalr  = 1'b0;
    w_a_is_pc  = 1'b0;
    w_b_is_imm = 1'b0;
    w_imm32    = 32'h0;
    w_alu_op   = ALU_ADD;
    w_res_sel  = RES_NONE;
    w_br_type  = BR_NONE;
    case (w_opcode)
      c_opc_lui: begin
        w_valid   = 1'b1;
        w_imm32   = w_imm_u;
        w_res_sel = RES_IMM;
      end
      c_opc_auipc: begin
        w_valid    = 1'b1;
        w_imm32    = w_imm_u;
        w_a_is_pc  = 1'b1;
        w_b_is_imm = 1'b1;
        w_res_sel  = RES_ALU;
      end
      c_opc_jal: begin
        w_valid   = 1'b1;
        w_is_ctrl = 1'b1;
        w_imm32   = w_imm_j;
        w_res_sel = RES_PC4;
        w_br_type = BR_JUMP;
      end
      c_opc_jalr: begin
        if (w_funct3 == 3'b000) begin
          w_valid   = 1'b1;
          w_is_ctrl = 1'b1;
          w_is_jalr = 1'b1;
          w_imm32   = w_imm_i;
          w_res_sel = RES_PC4;
          w_br_type = BR_JUMP;
        end
      end
      c_opc_branch: begin
        // Every funct3 is accepted; 010/011 simply never take.
        w_valid   = 1'b1;
        w_is_ctrl = 1'b1;
        w_imm32   = w_imm_b;
        case (w_funct3)
          3'b000:  w_br_type = BR_EQ;
          3'b001:  w_br_type = BR_NE;
          3'b100:  w_br_type = BR_LT;
          3'b101:  w_br_type = BR_GE;
          3'b110:  w_br_type = BR_LTU;
          3'b111:  w_br_type = BR_GEU;
          default: w_br_type = BR_NONE;
        endcase
      end
      c_opc_load: begin
        w_imm32 = w_imm_i;
        w_valid = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b010) ||
                  (w_funct3 == 3'b100) || (w_funct3 == 3'b101);
      end
      c_opc_store: begin
        w_imm32 = w_imm_s;
        w_valid = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b010);
      end
      c_opc_opimm: begin
        w_imm32    = w_imm_i;
        w_b_is_imm = 1'b1;
        w_res_sel  = RES_ALU;
        w_valid    = 1'b1;
        case (w_funct3)
          3'b000: w_alu_op = ALU_ADD;
          3'b010: w_alu_op = ALU_SLT;
          3'b011: w_alu_op = ALU_SLTU;
          3'b100: w_alu_op = ALU_XOR;
          3'b110: w_alu_op = ALU_OR;
          3'b111: w_alu_op = ALU_AND;
          3'b001: begin
            w_alu_op = ALU_SLL;
            w_valid  = (inst_i[31:26] == 6'b000000);
          end
          default: begin
            w_alu_op = inst_i[30] ? ALU_SRA : ALU_SRL;
            w_valid  = (inst_i[31:26] == 6'b000000) || (inst_i[31:26] == 6'b010000);
          end
        endcase
      end
      c_opc_op: begin
        w_valid   = 1'b1;
        w_res_sel = RES_ALU;
        case (w_funct3)
          3'b000:  w_alu_op = inst_i[30] ? ALU_SUB : ALU_ADD;
          3'b001:  w_alu_op = ALU_SLL;
          3'b010:  w_alu_op = ALU_SLT;
          3'b011:  w_alu_op = ALU_SLTU;
          3'b100:  w_alu_op = ALU_XOR;
          3'b101:  w_alu_op = inst_i[30] ? ALU_SRA : ALU_SRL;
          3'b110:  w_alu_op = ALU_OR;
          default: w_alu_op = ALU_AND;
        endcase
      end
      default: begin
        w_valid = w_is_ebreak;
      end
    endcase
  end

  // ------------------------------------------------------------- registers
  logic [DATA_LEN-1:0] w_rs1_data, w_rs2_data, w_wdata;
  logic                w_wen;

  rv32_regfile #(.DATA_LEN(DATA_LEN)) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .i_wen       (w_wen),
    .i_waddr     (inst_i[11:7]),
    .i_wdata     (w_wdata),
    .i_raddr1    (inst_i[19:15]),
    .o_rdata1    (w_rs1_data),
    .i_raddr2    (inst_i[24:20]),
    .o_rdata2    (w_rs2_data),
    .i_dbg_raddr (dbg_raddr_i),
    .o_dbg_rdata (dbg_rdata_o)
  );

  // ------------------------------------------------------------------- ALU
  logic [DATA_LEN-1:0] w_imm;
  logic [DATA_LEN-1:0] w_op_a, w_op_b, w_alu;
  logic [4:0]          w_shamt;

  assign w_imm   = DATA_LEN'($signed(w_imm32));
  assign w_op_a  = w_a_is_pc  ? DATA_LEN'(pc_i) : w_rs1_data;
  assign w_op_b  = w_b_is_imm ? w_imm : w_rs2_data;
  assign w_shamt = w_op_b[4:0];

  always_comb begin
    w_alu = '0;
    case (w_alu_op)
      ALU_ADD:   w_alu = w_op_a + w_op_b;
      ALU_SUB:   w_alu = w_op_a - w_op_b;
      ALU_SLL:   w_alu = w_op_a << w_shamt;
      ALU_SLT:   w_alu[0] = ($signed(w_op_a) < $signed(w_op_b));
      ALU_SLTU:  w_alu[0] = (w_op_a < w_op_b);
      ALU_XOR:   w_alu = w_op_a ^ w_op_b;
      ALU_SRL:   w_alu = w_op_a >> w_shamt;
      ALU_SRA:   w_alu = $signed(w_op_a) >>> w_shamt;
      ALU_OR:    w_alu = w_op_a | w_op_b;
      ALU_AND:   w_alu = w_op_a & w_op_b;
      ALU_PASSB: w_alu = w_op_b;
      default:   w_alu = '0;
    endcase
  end

  // ---------------------------------------------------------------- branch
  logic                w_cond;
  logic                w_take;
  logic [ADDR_LEN-1:0] w_pc4, w_rel_tgt, w_jalr_tgt;
  logic [DATA_LEN-1:0] w_jalr_sum;

  always_comb begin
    w_cond = 1'b0;
    case (w_br_type)
      BR_EQ:   w_cond = (w_rs1_data == w_rs2_data);
      BR_NE:   w_cond = (w_rs1_data != w_rs2_data);
      BR_LT:   w_cond = ($signed(w_rs1_data) <  $signed(w_rs2_data));
      BR_GE:   w_cond = ($signed(w_rs1_data) >= $signed(w_rs2_data));
      BR_LTU:  w_cond = (w_rs1_data <  w_rs2_data);
      BR_GEU:  w_cond = (w_rs1_data >= w_rs2_data);
      BR_JUMP: w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_take     = rst && w_valid && w_cond;
  assign w_pc4      = pc_i + ADDR_LEN'(4);
  assign w_rel_tgt  = pc_i + ADDR_LEN'($signed(w_imm32));
  // rs1 comes straight from the register file, i.e. the value before this
  // instruction's own write, so rd==rs1 needs no special handling.
  assign w_jalr_sum = w_rs1_data + w_imm;
  assign w_jalr_tgt = ADDR_LEN'(w_jalr_sum) & ~ADDR_LEN'(1);

  assign branch_flag_o    = w_is_ctrl;
  assign branch_request_o = w_take;
  assign branch_target_o  = !w_take   ? w_pc4 :
                            w_is_jalr ? w_jalr_tgt : w_rel_tgt;
  assign invalid_o        = !w_valid;
  assign ebreak_o         = w_is_ebreak;

  // ------------------------------------------------------------ write-back
  assign w_wen = rst && w_valid && (w_res_sel != RES_NONE);

  always_comb begin
    w_wdata = w_alu;
    case (w_res_sel)
      RES_PC4: w_wdata = DATA_LEN'(w_pc4);
      RES_IMM: w_wdata = w_imm;
      default: w_wdata = w_alu;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32_decode_execute_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32_decode_execute_unit
//  Description : Directed self-checking bench for rv32_decode_execute_unit.
//                Inputs are driven 1 time unit after a rising edge and
//                outputs are compared a few units later, clear of the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_decode_execute_unit;

  localparam logic [6:0] c_lui   = 7'b0110111;
  localparam logic [6:0] c_jalr  = 7'b1100111;
  localparam logic [6:0] c_load  = 7'b0000011;
  localparam logic [6:0] c_opimm = 7'b0010011;

  logic        clk;
  logic        rst;
  logic [31:0] inst_i;
  logic [31:0] pc_i;
  logic        branch_flag_o;
  logic        branch_request_o;
  logic [31:0] branch_target_o;
  logic        invalid_o;
  logic        ebreak_o;
  logic [4:0]  dbg_raddr_i;
  logic [31:0] dbg_rdata_o;

  int checks = 0;
  int errors = 0;

  rv32_decode_execute_unit #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .inst_i           (inst_i),
    .pc_i             (pc_i),
    .branch_flag_o    (branch_flag_o),
    .branch_request_o (branch_request_o),
    .branch_target_o  (branch_target_o),
    .invalid_o        (invalid_o),
    .ebreak_o         (ebreak_o),
    .dbg_raddr_i      (dbg_raddr_i),
    .dbg_rdata_o      (dbg_rdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ encoders
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  // ------------------------------------------------------------- helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    inst_i = inst;
    pc_i   = pc;
    #2;
  endtask

  // Commit the applied instruction, then park an invalid word on the bus so
  // later register reads cannot be disturbed by further edges.
  task automatic tick();
    @(posedge clk);
    #1;
    inst_i = 32'h0;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    dbg_raddr_i = r;
    #1;
    chk(tag, dbg_rdata_o, exp);
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    rst         = 1'b0;
    dbg_raddr_i = 5'd0;
    // 1. reset: jal must not request nor write while held
    drive(enc_j(21'h20, 5'd1), 32'h8000_0000);
    chk("rst_branch_req", {31'b0, branch_request_o}, 32'h0);
    chk("rst_target_pc4", branch_target_o, 32'h8000_0004);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reg("rst_no_write_x1", 5'd1, 32'h0);
    inst_i = 32'h0;
    rst    = 1'b1;
    for (int r = 1; r < 32; r++) begin
      chk_reg($sformatf("rst_clear_x%0d", r), 5'(r), 32'h0);
    end

    // 2. immediate ops
    drive(32'hFFB0_0093, 32'h0);                       // addi x1,x0,-5
    chk("addi_invalid", {31'b0, invalid_o}, 32'h0);
    chk("addi_no_branch", {31'b0, branch_request_o}, 32'h0);
    chk("addi_flag", {31'b0, branch_flag_o}, 32'h0);
    tick();
    chk_reg("addi_x1", 5'd1, 32'hFFFF_FFFB);
    drive(enc_i(12'h000, 5'd1, 3'b010, 5'd2, c_opimm), 32'h0); tick();   // slti
    drive(enc_i(12'h001, 5'd1, 3'b011, 5'd3, c_opimm), 32'h0); tick();   // sltiu
    chk_reg("slti_x2", 5'd2, 32'h1);
    chk_reg("sltiu_x3", 5'd3, 32'h0);
    drive(enc_i(12'h007, 5'd0, 3'b000, 5'd0, c_opimm), 32'h0); tick();   // addi x0
    chk_reg("x0_stays_zero", 5'd0, 32'h0);

    // 3. register-register ops
    drive(enc_u(20'h80000, 5'd1, c_lui), 32'h0); tick();
    drive(enc_i(12'h004, 5'd0, 3'b000, 5'd2, c_opimm), 32'h0); tick();
    chk_reg("lui_x1", 5'd1, 32'h8000_0000);
    drive(enc_r(7'b0100000, 5'd2, 5'd1, 3'b101, 5'd4), 32'h0); tick();   // sra
    drive(enc_r(7'b0000000, 5'd2, 5'd1, 3'b101, 5'd5), 32'h0); tick();   // srl
    drive(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd6), 32'h0); tick();   // sub
    drive(enc_i(12'h404, 5'd1, 3'b101, 5'd10, c_opimm), 32'h0); tick();  // srai 4
    drive(enc_r(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd11), 32'h0); tick();  // xor
    drive(enc_r(7'b0000000, 5'd2, 5'd1, 3'b010, 5'd12), 32'h0); tick();  // slt
    drive(enc_r(7'b0000000, 5'd1, 5'd2, 3'b011, 5'd13), 32'h0); tick();  // sltu x2<x1
    chk_reg("sra", 5'd4, 32'hF800_0000);
    chk_reg("srl", 5'd5, 32'h0800_0000);
    chk_reg("sub", 5'd6, 32'h7FFF_FFFC);
    chk_reg("srai", 5'd10, 32'hF800_0000);
    chk_reg("xor", 5'd11, 32'h8000_0004);
    chk_reg("slt", 5'd12, 32'h1);
    chk_reg("sltu", 5'd13, 32'h1);
    drive(enc_i(12'hFFF, 5'd0, 3'b000, 5'd7, c_opimm), 32'h0); tick();
    drive(enc_i(12'h001, 5'd0, 3'b000, 5'd8, c_opimm), 32'h0); tick();
    chk_reg("x7_all_ones", 5'd7, 32'hFFFF_FFFF);
    drive(enc_r(7'b0000000, 5'd8, 5'd7, 3'b000, 5'd7), 32'h0); tick();  // add wraps
    chk_reg("add_wrap", 5'd7, 32'h0);
    drive(enc_i(12'h401, 5'd1, 3'b001, 5'd1, c_opimm), 32'h0);           // bad slli
    chk("slli_bad_invalid", {31'b0, invalid_o}, 32'h1);
    tick();
    chk_reg("slli_bad_no_write", 5'd1, 32'h8000_0000);

    // 4. conditional branches, x1=-1 x2=1
    drive(enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, c_opimm), 32'h0); tick();
    drive(enc_i(12'h001, 5'd0, 3'b000, 5'd2, c_opimm), 32'h0); tick();
    drive(enc_b(13'h0008, 5'd2, 5'd1, 3'b100), 32'h8000_0010);          // blt
    chk("blt_flag", {31'b0, branch_flag_o}, 32'h1);
    chk("blt_req", {31'b0, branch_request_o}, 32'h1);
    chk("blt_target", branch_target_o, 32'h8000_0018);
    tick();
    chk_reg("blt_no_write_x8", 5'd8, 32'h1);
    drive(enc_b(13'h0008, 5'd2, 5'd1, 3'b110), 32'h8000_0010);          // bltu
    chk("bltu_flag", {31'b0, branch_flag_o}, 32'h1);
    chk("bltu_req", {31'b0, branch_request_o}, 32'h0);
    chk("bltu_target", branch_target_o, 32'h8000_0014);
    drive(enc_b(13'h1FF0, 5'd1, 5'd1, 3'b000), 32'h8000_0010);          // beq -16
    chk("beq_req", {31'b0, branch_request_o}, 32'h1);
    chk("beq_target", branch_target_o, 32'h8000_0000);
    drive(enc_b(13'h0008, 5'd2, 5'd1, 3'b101), 32'h8000_0010);          // bge
    chk("bge_req", {31'b0, branch_request_o}, 32'h0);
    drive(enc_b(13'h0008, 5'd2, 5'd1, 3'b111), 32'h8000_0010);          // bgeu
    chk("bgeu_req", {31'b0, branch_request_o}, 32'h1);
    drive(enc_b(13'h0008, 5'd2, 5'd1, 3'b001), 32'h8000_0010);          // bne
    chk("bne_req", {31'b0, branch_request_o}, 32'h1);
    drive(enc_b(13'h0008, 5'd1, 5'd1, 3'b010), 32'h8000_0010);          // undefined
    chk("b010_req", {31'b0, branch_request_o}, 32'h0);
    chk("b010_invalid", {31'b0, invalid_o}, 32'h0);

    // 5. jumps
    drive(enc_j(21'h20, 5'd1), 32'h8000_0000);
    chk("jal_req", {31'b0, branch_request_o}, 32'h1);
    chk("jal_target", branch_target_o, 32'h8000_0020);
    tick();
    chk_reg("jal_link", 5'd1, 32'h8000_0004);
    drive(enc_i(12'h003, 5'd1, 3'b000, 5'd1, c_jalr), 32'h8000_0020);
    chk("jalr_req", {31'b0, branch_request_o}, 32'h1);
    chk("jalr_target", branch_target_o, 32'h8000_0006);
    tick();
    chk_reg("jalr_link", 5'd1, 32'h8000_0024);
    drive(enc_i(12'h003, 5'd1, 3'b001, 5'd1, c_jalr), 32'h8000_0020);
    chk("jalr_f3_invalid", {31'b0, invalid_o}, 32'h1);
    chk("jalr_f3_req", {31'b0, branch_request_o}, 32'h0);

    // 6. status flags
    drive(32'h0010_0073, 32'h0);
    chk("ebreak_flag", {31'b0, ebreak_o}, 32'h1);
    chk("ebreak_invalid", {31'b0, invalid_o}, 32'h0);
    chk("ebreak_req", {31'b0, branch_request_o}, 32'h0);
    drive(32'h0000_0000, 32'h0);
    chk("zero_invalid", {31'b0, invalid_o}, 32'h1);
    chk("zero_ebreak", {31'b0, ebreak_o}, 32'h0);
    drive(enc_i(12'h000, 5'd0, 3'b000, 5'd1, 7'b0001011), 32'h0);       // custom opc, rd=x1
    chk("custom_invalid", {31'b0, invalid_o}, 32'h1);
    tick();
    chk_reg("custom_no_write", 5'd1, 32'h8000_0024);
    drive(enc_i(12'h000, 5'd2, 3'b010, 5'd1, c_load), 32'h0);           // lw x1,0(x2)
    chk("lw_invalid", {31'b0, invalid_o}, 32'h0);
    tick();
    chk_reg("lw_no_write", 5'd1, 32'h8000_0024);

    // asynchronous clear without a clock edge
    #1;
    rst = 1'b0;
    #1;
    chk_reg("async_clear_x1", 5'd1, 32'h0);
    chk_reg("async_clear_x4", 5'd4, 32'h0);
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
